// File: rtl/sr_iter_shifter_pkg.sv
// Shared definitions for the iterative right-shift unit: default sizes and FSM encoding.
// The unused encoding 2'd3 is treated as IDLE by the FSM's default branch.
package sr_iter_shifter_pkg;

    localparam int unsigned DEFAULT_WIDTH   = 16;
    localparam int unsigned DEFAULT_SHAMT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } sr_state_t;

    // Reference one-bit right shift.
    function automatic logic [DEFAULT_WIDTH-1:0] sr_step_ref(
        input logic [DEFAULT_WIDTH-1:0] value,
        input logic                     arith
    );
        return {arith & value[DEFAULT_WIDTH-1], value[DEFAULT_WIDTH-1:1]};
    endfunction

endpackage

// File: rtl/sr_iter_shifter_step.sv
// Combinational single-bit right shift. The vacated MSB takes the sign bit in
// arithmetic mode and zero in logical mode.
module sr_step #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] value,
    input  logic             arith,
    output logic [WIDTH-1:0] shifted
);

    assign shifted = {arith & value[WIDTH-1], value[WIDTH-1:1]};

endmodule

// File: rtl/sr_iter_shifter.sv
// Multi-cycle right shifter: one bit per clock, logical or arithmetic, with a
// start/busy/done handshake toward the control FSM.
module sr_iter_shifter
    import sr_iter_shifter_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter int unsigned SHAMT_W = DEFAULT_SHAMT_W
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               arith,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               done
);

    sr_state_t          state;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   work_shifted;
    logic [SHAMT_W-1:0] count;
    logic               mode;

    sr_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .value   (work),
        .arith   (mode),
        .shifted (work_shifted)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            work     <= '0;
            count    <= '0;
            mode     <= 1'b0;
            data_out <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work  <= data_in;
                        count <= shamt;
                        mode  <= arith;
                        busy  <= 1'b1;
                        state <= (shamt != '0) ? SHIFT : FINISH;
                    end
                end
                SHIFT: begin
                    work  <= work_shifted;
                    count <= count - SHAMT_W'(1);
                    if (count == SHAMT_W'(1)) begin
                        state <= FINISH;
                    end
                end
                FINISH: begin
                    data_out <= work;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sr_iter_shifter.sv
// Randomized and directed checks of sr_iter_shifter against a plain-arithmetic
// shift model with a latency of shamt+1 edges.
module tb_sr_iter_shifter;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] data_in;
    logic [3:0]  shamt;
    logic        arith;
    logic [15:0] data_out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;

    sr_iter_shifter #(
        .WIDTH   (16),
        .SHAMT_W (4)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .data_in  (data_in),
        .shamt    (shamt),
        .arith    (arith),
        .data_out (data_out),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] d, input int n, input logic a);
        if (a) return 16'($signed(d) >>> n);
        return d >> n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from mid-cycle, scramble the inputs after acceptance and
    // follow it to completion. Returns in the done cycle.
    task automatic run_op(input logic [15:0] d, input logic [3:0] n, input logic a,
                          input string tag);
        logic [15:0] exp;
        int          lat;
        int          busy_cycles;
        bit          seen;
        exp     = model(d, int'(n), a);
        start   = 1'b1;
        data_in = d;
        shamt   = n;
        arith   = a;
        tick();
        start   = 1'b0;
        data_in = 16'($urandom);
        shamt   = 4'($urandom);
        arith   = 1'($urandom);
        lat         = 0;
        busy_cycles = 0;
        seen        = 0;
        while (!seen && lat <= 40) begin
            if (done) begin
                seen = 1;
            end else begin
                if (busy) busy_cycles++;
                tick();
                lat++;
            end
        end
        check({tag, " done_seen"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(int'(n) + 1));
        check({tag, " data_out"}, 32'(data_out), 32'(exp));
        check({tag, " busy_at_done"}, 32'(busy), 32'd0);
        check({tag, " busy_cycles"}, 32'(busy_cycles), 32'(int'(n) + 1));
    endtask

    initial begin
        logic [15:0] held;
        int          ndone;
        int          lat;
        start   = 1'b0;
        data_in = '0;
        shamt   = '0;
        arith   = 1'b0;
        reset_n = 1'b0;
        #2;
        check("reset data_out", 32'(data_out), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        #10 reset_n = 1'b1;
        tick();
        check("idle busy", 32'(busy), 32'd0);

        run_op(16'd1000, 4'd1, 1'b0, "logical");
        tick();
        check("done single pulse", 32'(done), 32'd0);
        run_op(16'h8000, 4'd15, 1'b1, "arith15");
        check("arith15 all sign", 32'(data_out), 32'hFFFF);
        tick();
        run_op(16'h8000, 4'd15, 1'b0, "logic15");
        check("logic15 value", 32'(data_out), 32'h0001);
        tick();

        run_op(16'h1234, 4'd0, 1'b0, "zero");
        run_op(16'hF0F0, 4'd4, 1'b1, "b2b");
        check("b2b value", 32'(data_out), 32'hFF0F);

        // Start while busy must be ignored.
        tick();
        start = 1'b1; data_in = 16'h0100; shamt = 4'd8; arith = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1; data_in = 16'hFFFF; shamt = 4'd2; arith = 1'b1;
        tick();
        start = 1'b0;
        lat   = 3;
        ndone = 0;
        while (ndone == 0 && lat <= 40) begin
            if (done) ndone++;
            else begin tick(); lat++; end
        end
        check("busy_ign latency", 32'(lat), 32'd9);
        check("busy_ign data_out", 32'(data_out), 32'h0001);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) ndone++;
        end
        check("busy_ign done count", 32'(ndone), 32'd1);

        // Hold: no start for 20 cycles.
        held = data_out;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold data_out", 32'(data_out), 32'(held));
            check("hold done", 32'(done), 32'd0);
            check("hold busy", 32'(busy), 32'd0);
        end

        // Asynchronous reset mid-operation.
        run_op(16'hABCD, 4'd3, 1'b0, "pre_reset");
        start = 1'b1; data_in = 16'h7FFF; shamt = 4'd10; arith = 1'b0;
        tick();
        start = 1'b0;
        repeat (4) tick();
        #2 reset_n = 1'b0;
        #1;
        check("async data_out", 32'(data_out), 32'd0);
        check("async busy", 32'(busy), 32'd0);
        check("async done", 32'(done), 32'd0);
        #2 reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done || busy) ndone++;
        end
        check("post_reset quiet", 32'(ndone), 32'd0);

        // Randomized traffic with random gaps, including zero-gap back-to-back.
        for (int k = 0; k < 40; k++) begin
            int gap;
            run_op(16'($urandom), 4'($urandom), 1'($urandom), "rand");
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                tick();
                check("rand gap done", 32'(done), 32'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
